fu_rr_arbiter: RTL
==================

Name: fu_rr_arbiter

Overview:
- Round-robin arbiter that shares one functional-unit issue port (e.g. the multiplier) among N reservation-station requesters.
- Registered one-hot grant with a valid/ready handshake to the FU.
- Rotating priority pointer gives starvation-free service.
- Sits between RS entry request lines and the FU input mux; gnt drives the mux select directly.

Parameters:
- N, 16, number of requesters; power of two, 2..16.
- PTR_W, $clog2(N), width of the priority pointer and grant index.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low (0 = reset, sampled on rising clock).
- req  input  N  per-requester request; level, held by the requester until granted or withdrawn.
- fu_ready  input  1  FU accepts the granted operation this cycle.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  high when gnt is non-zero.
- gnt_idx  output  PTR_W  binary index of the granted requester; 0 when idle.
- busy  output  1  FSM in GRANT state.

Behaviour:
- Reset (reset==0 at a clock edge):
  - gnt=0, gnt_valid=0, gnt_idx=0, busy=0.
  - Pointer ptr=0; state=IDLE.
  - Takes precedence over every other event, including a handshake in the same cycle.
- Winner selection (combinational): first set bit of req searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wraps mod N).
- States: IDLE and GRANT.
- IDLE:
  - If |req, register the winner into gnt/gnt_idx, set gnt_valid=1 and go to GRANT.
  - Otherwise stay in IDLE.
  - Latency: req rising in cycle t -> gnt visible in cycle t+1.
- GRANT:
  - gnt, gnt_idx and ptr are held stable until fu_ready or withdrawal; fu_ready is ignored in IDLE.
  - Handshake: fu_ready==1 completes it. ptr <= (gnt_idx+1) mod N.
    - If (req & ~gnt) != 0, register the winner among the other requesters, using the updated ptr, next cycle; stay in GRANT (back-to-back, no bubble).
    - Otherwise clear gnt and go to IDLE.
    - The just-served requester can win again only from IDLE, i.e. after a one-cycle bubble, and only if no other requester is present.
  - Withdrawal: req[gnt_idx]==0 and fu_ready==0 -> clear gnt next cycle, go to IDLE, ptr unchanged.
  - Simultaneous handshake and withdrawal: fu_ready wins; treated as a completed handshake.
- Wrap-around: gnt_idx==N-1 completing -> ptr=0.
- Invariant: gnt is never multi-hot.
- Invariant: gnt_valid == |gnt, and gnt_valid == busy.
- Arithmetic: pointer increment is modulo N; no other width growth.

Optional Feature:
- Macro: FU_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0]: counts cycles in GRANT with fu_ready==0.
  - Saturates at 16'hFFFF.
  - Reset to 0 by reset; never cleared otherwise.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: reset=0 for 2 cycles with req=16'hFFFF -> gnt=0, gnt_valid=0, busy=0. Release -> next cycle gnt=16'h0001, gnt_idx=0.
- Rotation: req=16'hFFFF held, fu_ready=1 every cycle -> gnt_idx sequence 0,1,2,...,15,0 with no idle cycles.
- Stall hold:
  - req=16'h0110, fu_ready=0 for 5 cycles -> gnt=16'h0010 stable for 5 cycles; stall_cnt=5 when the macro is defined.
  - Then fu_ready=1 -> next gnt=16'h0100.
- Withdrawal: granted idx 3, drop req[3] with fu_ready=0 -> next cycle gnt=0, busy=0. ptr unchanged, so re-raised req[3] with req[7] -> idx 3 granted first.
- Wrap/back-to-back: ptr=15, req=16'h8001 -> idx 15 granted; on handshake the next grant is idx 0 the following cycle.
- Reset mid-grant: in GRANT with fu_ready=1, assert reset=0 -> next cycle all outputs 0, ptr=0, state IDLE.

Source files
------------

// File: rtl/fu_rr_arbiter.sv
// fu_rr_arbiter
//   Round-robin arbiter sharing one functional-unit issue port among N
//   reservation-station requesters. The grant is registered and one-hot, and
//   drives the FU input mux select directly. A rotating priority pointer
//   guarantees starvation-free service.
//
// Parameters
//   N      number of requesters (power of two, 2..16)
//   PTR_W  width of the priority pointer / grant index
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous active-low reset
//   req        per-requester level request
//   fu_ready   FU accepts the granted operation this cycle
//   gnt        registered one-hot grant, all-zero when idle
//   gnt_valid  grant present (== |gnt)
//   gnt_idx    binary index of the granted requester, 0 when idle
//   busy       arbiter holds a grant
//   stall_cnt  saturating count of granted cycles without fu_ready
//              (only when FU_ARB_STALL_CNT_EN is defined)
module fu_rr_arbiter #(
    parameter int unsigned N     = 16,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             fu_ready,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             busy
`ifdef FU_ARB_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_n;
    logic [N-1:0]     gnt_n;
    logic [PTR_W-1:0] gnt_idx_n;
    logic [PTR_W-1:0] ptr, ptr_n;

    logic [PTR_W-1:0] sel_ptr;
    logic [N-1:0]     sel_req;
    logic [PTR_W-1:0] idx_try;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;

    // In GRANT the winner is only used on a handshake, so search from the
    // post-handshake pointer and exclude the requester being served; this
    // gives back-to-back grants without a bubble.
    always_comb begin
        sel_ptr   = (state == GRANT) ? gnt_idx + PTR_W'(1) : ptr;
        sel_req   = (state == GRANT) ? (req & ~gnt) : req;
        idx_try   = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            // PTR_W-bit addition wraps mod N since N is a power of two
            idx_try = sel_ptr + PTR_W'(i);
            if (!win_found && sel_req[idx_try]) begin
                win_found = 1'b1;
                win_idx   = idx_try;
            end
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_idx_n = gnt_idx;
        ptr_n     = ptr;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_n          = '0;
                    gnt_n[win_idx] = 1'b1;
                    gnt_idx_n      = win_idx;
                    state_n        = GRANT;
                end
            end
            GRANT: begin
                if (fu_ready) begin
                    ptr_n = gnt_idx + PTR_W'(1);
                    if (win_found) begin
                        gnt_n          = '0;
                        gnt_n[win_idx] = 1'b1;
                        gnt_idx_n      = win_idx;
                    end else begin
                        gnt_n     = '0;
                        gnt_idx_n = '0;
                        state_n   = IDLE;
                    end
                end else if (!req[gnt_idx]) begin
                    // Withdrawal: drop the grant, keep the pointer
                    gnt_n     = '0;
                    gnt_idx_n = '0;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_idx <= gnt_idx_n;
            ptr     <= ptr_n;
        end
    end

    assign busy      = (state == GRANT);
    assign gnt_valid = (state == GRANT);

`ifdef FU_ARB_STALL_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (state == GRANT && !fu_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
